// File: rtl/coherent_rd_pacer_pkg.sv
// Shared types and widths for the coherent read pacer and its hold timer.
package sync_coherent_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } pacer_state_t;

    localparam int HOLD_CNT_W    = 16;
    localparam int STATS_UPD_W   = 32;
    localparam int STATS_STALL_W = 16;

endpackage

// File: rtl/coherent_rd_pacer_hold_timer.sv
// Loadable 16-bit down-counter that times the dwell of each popped value.
// expire is high while the count sits at 1, the last cycle of a hold.
module hold_timer
    import sync_coherent_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  load,
    input  logic [HOLD_CNT_W-1:0] load_value,
    input  logic                  count_en,
    output logic [HOLD_CNT_W-1:0] value,
    output logic                  expire
);

    // Load on a pop, otherwise count down while enabled, never below zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (count_en && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

    assign expire = (value == HOLD_CNT_W'(1));

endmodule

// File: rtl/coherent_rd_pacer.sv
// Paces pops from a first-word-fall-through FIFO so that every queued value
// is held on dout for at least HOLD_CYCLES clocks, in order.
// Define COHERENT_RD_PACER_STATS_EN to add update_count/stall_count ports.
module coherent_rd_pacer
    import sync_coherent_pkg::*;
#(
    parameter int               WIDTH        = 1,
    parameter int               HOLD_CYCLES  = 4,
    parameter logic [WIDTH-1:0] DOUT_DEFAULT = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             pause,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_update,
    output logic             busy
`ifdef COHERENT_RD_PACER_STATS_EN
    ,
    output logic [STATS_UPD_W-1:0]   update_count,
    output logic [STATS_STALL_W-1:0] stall_count
`endif
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD  = HOLD_CNT_W'(HOLD_CYCLES - 1);
    localparam bit                    MULTI_HOLD = (HOLD_CYCLES > 1);

    pacer_state_t          state_q;
    pacer_state_t          state_d;
    logic                  pop_go;
    logic                  hold_expire;
    logic [HOLD_CNT_W-1:0] hold_value;

    // resetn gates the strobe so the FIFO is never popped while in reset.
    assign pop_go     = resetn && (state_q == IDLE) && !fifo_empty && !pause && !clear;
    assign fifo_rd_en = pop_go;
    assign busy       = (state_q == HOLD);

    hold_timer u_hold_timer (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (clear),
        .load       (pop_go),
        .load_value (HOLD_LOAD),
        .count_en   (state_q == HOLD),
        .value      (hold_value),
        .expire     (hold_expire)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter HOLD on a pop (unless single-cycle dwell), leave when the timer expires.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (pop_go && MULTI_HOLD) state_d = HOLD;
                HOLD: if (hold_expire)          state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output register: capture the FIFO head on a pop and pulse dout_update afterwards.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout        <= DOUT_DEFAULT;
            dout_update <= 1'b0;
        end else if (clear) begin
            dout        <= DOUT_DEFAULT;
            dout_update <= 1'b0;
        end else begin
            dout_update <= pop_go;
            if (pop_go) begin
                dout <= fifo_rd_data;
            end
        end
    end

`ifdef COHERENT_RD_PACER_STATS_EN
    logic stall_event;
    assign stall_event = !fifo_empty && !pop_go;

    // Saturating counters of pops and of cycles where data waited behind a hold or pause.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            update_count <= '0;
            stall_count  <= '0;
        end else if (clear) begin
            update_count <= '0;
            stall_count  <= '0;
        end else begin
            if (pop_go && (update_count != '1)) begin
                update_count <= update_count + 1'b1;
            end
            if (stall_event && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_coherent_rd_pacer.sv
// Directed bench for coherent_rd_pacer: a 4-cycle dwell instance (a) and a
// 1-cycle dwell instance (b), each fed by a queue modelling a FWFT FIFO.
module tb_coherent_rd_pacer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       clear_a, pause_a, clear_b, pause_b;
    logic       empty_a, empty_b;
    logic [7:0] data_a, data_b;
    logic       rd_en_a, rd_en_b;
    logic [7:0] dout_a, dout_b;
    logic       upd_a, upd_b, busy_a, busy_b;
`ifdef COHERENT_RD_PACER_STATS_EN
    logic [31:0] upd_cnt_a, upd_cnt_b;
    logic [15:0] stall_cnt_a, stall_cnt_b;
`endif

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic       seen_a, seen_b;
    logic [7:0] popped;
    int         checks = 0;
    int         failures = 0;
    int         pulses;

    always #5 clk = ~clk;

    coherent_rd_pacer #(.WIDTH(8), .HOLD_CYCLES(4), .DOUT_DEFAULT(8'hEE)) dut_a (
        .clk(clk), .resetn(resetn), .clear(clear_a), .pause(pause_a),
        .fifo_empty(empty_a), .fifo_rd_data(data_a), .fifo_rd_en(rd_en_a),
        .dout(dout_a), .dout_update(upd_a), .busy(busy_a)
`ifdef COHERENT_RD_PACER_STATS_EN
        , .update_count(upd_cnt_a), .stall_count(stall_cnt_a)
`endif
    );

    coherent_rd_pacer #(.WIDTH(8), .HOLD_CYCLES(1), .DOUT_DEFAULT(8'h00)) dut_b (
        .clk(clk), .resetn(resetn), .clear(clear_b), .pause(pause_b),
        .fifo_empty(empty_b), .fifo_rd_data(data_b), .fifo_rd_en(rd_en_b),
        .dout(dout_b), .dout_update(upd_b), .busy(busy_b)
`ifdef COHERENT_RD_PACER_STATS_EN
        , .update_count(upd_cnt_b), .stall_count(stall_cnt_b)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic refreshFifo();
        empty_a = (q_a.size() == 0);
        data_a  = empty_a ? 8'h00 : q_a[0];
        empty_b = (q_b.size() == 0);
        data_b  = empty_b ? 8'h00 : q_b[0];
    endtask

    task automatic applyStimulus(input bit to_b, input logic [7:0] word);
        if (to_b) q_b.push_back(word);
        else      q_a.push_back(word);
        refreshFifo();
    endtask

    // One clock: sample the pop strobes mid-cycle, then pop the model FIFOs after the edge.
    task automatic tick();
        @(negedge clk);
        seen_a = rd_en_a;
        seen_b = rd_en_b;
        @(posedge clk);
        #1;
        if (seen_a && q_a.size() > 0) popped = q_a.pop_front();
        if (seen_b && q_b.size() > 0) popped = q_b.pop_front();
        refreshFifo();
    endtask

    initial begin
        clear_a = 0; pause_a = 0; clear_b = 0; pause_b = 0;
        refreshFifo();
        resetn = 1'b1;
        #1 resetn = 1'b0;

        // Reset state, with a word waiting that must not be popped.
        applyStimulus(0, 8'h77);
        tick();
        checkOutput("rst_rd_en", 32'(seen_a), 32'd0);
        checkOutput("rst_dout", 32'(dout_a), 32'hEE);
        checkOutput("rst_upd", 32'(upd_a), 32'd0);
        checkOutput("rst_busy", 32'(busy_a), 32'd0);
        q_a.delete();
        refreshFifo();
        resetn = 1'b1;

        // Empty FIFO after reset release: nothing moves for 20 cycles.
        for (int k = 0; k < 20; k++) begin
            tick();
            checkOutput("idle_rd_en", 32'(seen_a), 32'd0);
            checkOutput("idle_upd", 32'(upd_a), 32'd0);
            checkOutput("idle_dout", 32'(dout_a), 32'hEE);
        end

        // Three words, dwell 4: pops on ticks 1, 5, 9.
        applyStimulus(0, 8'h01);
        applyStimulus(0, 8'h02);
        applyStimulus(0, 8'h03);
        pulses = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            checkOutput($sformatf("seq_rd_en_%0d", k), 32'(seen_a), 32'((k % 4 == 1) && (k <= 9)));
            checkOutput($sformatf("seq_dout_%0d", k), 32'(dout_a), (k < 5) ? 32'h1 : (k < 9) ? 32'h2 : 32'h3);
            checkOutput($sformatf("seq_busy_%0d", k), 32'(busy_a), 32'((k % 4 != 0) && (k <= 11)));
            if (upd_a) pulses++;
        end
        checkOutput("seq_pulses", 32'(pulses), 32'd3);
`ifdef COHERENT_RD_PACER_STATS_EN
        checkOutput("stat_updates", upd_cnt_a, 32'd3);
        checkOutput("stat_stalls", 32'(stall_cnt_a), 32'd6);
`endif
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        checkOutput("clr_idle_dout", 32'(dout_a), 32'hEE);
`ifdef COHERENT_RD_PACER_STATS_EN
        checkOutput("stat_upd_clr", upd_cnt_a, 32'd0);
        checkOutput("stat_stall_clr", 32'(stall_cnt_a), 32'd0);
`endif

        // Pause during a hold: timer still expires, pop follows pause release.
        applyStimulus(0, 8'h10);
        applyStimulus(0, 8'h20);
        tick();
        checkOutput("pause_first_pop", 32'(seen_a), 32'd1);
        pause_a = 1'b1;
        for (int k = 2; k <= 7; k++) begin
            tick();
            checkOutput($sformatf("pause_rd_en_%0d", k), 32'(seen_a), 32'd0);
            checkOutput($sformatf("pause_dout_%0d", k), 32'(dout_a), 32'h10);
            checkOutput($sformatf("pause_busy_%0d", k), 32'(busy_a), 32'(k < 4));
        end
        pause_a = 1'b0;
        tick();
        checkOutput("unpause_rd_en", 32'(seen_a), 32'd1);
        checkOutput("unpause_dout", 32'(dout_a), 32'h20);
        checkOutput("unpause_upd", 32'(upd_a), 32'd1);
        repeat (4) tick();

        // Clear in the middle of a hold on 0x0A.
        applyStimulus(0, 8'h0A);
        applyStimulus(0, 8'h0B);
        tick();
        tick();
        checkOutput("midhold_dout", 32'(dout_a), 32'h0A);
        checkOutput("midhold_busy", 32'(busy_a), 32'd1);
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        checkOutput("clr_rd_en", 32'(seen_a), 32'd0);
        checkOutput("clr_dout", 32'(dout_a), 32'hEE);
        checkOutput("clr_busy", 32'(busy_a), 32'd0);
        checkOutput("clr_upd", 32'(upd_a), 32'd0);
        tick();
        checkOutput("after_clr_rd_en", 32'(seen_a), 32'd1);
        checkOutput("after_clr_dout", 32'(dout_a), 32'h0B);
        checkOutput("after_clr_busy", 32'(busy_a), 32'd1);
        repeat (3) tick();
        checkOutput("hold_done_busy", 32'(busy_a), 32'd0);

        // Clear while idle with data waiting suppresses that cycle's pop.
        applyStimulus(0, 8'h0C);
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        checkOutput("clr_idle_rd_en", 32'(seen_a), 32'd0);
        checkOutput("clr_idle_dout2", 32'(dout_a), 32'hEE);
        tick();
        checkOutput("post_clr_rd_en", 32'(seen_a), 32'd1);
        checkOutput("post_clr_dout", 32'(dout_a), 32'h0C);
        repeat (4) tick();

        // Dwell of 1: five back-to-back pops.
        for (int k = 0; k < 5; k++) applyStimulus(1, 8'h21 + 8'(k));
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("b2b_rd_en_%0d", k), 32'(seen_b), 32'd1);
            checkOutput($sformatf("b2b_dout_%0d", k), 32'(dout_b), 32'h21 + 32'(k));
            checkOutput($sformatf("b2b_upd_%0d", k), 32'(upd_b), 32'd1);
            checkOutput($sformatf("b2b_busy_%0d", k), 32'(busy_b), 32'd0);
        end
        tick();
        checkOutput("b2b_drained_rd_en", 32'(seen_b), 32'd0);
        checkOutput("b2b_drained_upd", 32'(upd_b), 32'd0);
        checkOutput("b2b_drained_dout", 32'(dout_b), 32'h25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
